// File: rtl/ddr3_reset_n_sequencer.sv
// DDR3 RESET_N lane sequencer: JEDEC power-up waveform as 4-bit TX/OE words,
// delay-line load/move control with tap tracking, and CKE enable timing.
module ddr3_reset_n_sequencer #(
  parameter int T_RESET_CYCLES = 33300,
  parameter int T_CKE_CYCLES   = 83250,
  parameter int MOVE_GAP       = 4,
  parameter int TAP_MAX        = 127
) (
  input  logic       FAB_CLK,
  input  logic       TX_SYNC_RST,
  input  logic       INIT_REQ,
  input  logic       TAP_MOVE_REQ,
  input  logic       TAP_DIR,
  input  logic       DELAY_LINE_OUT_OF_RANGE_0,
  output logic [3:0] TX_DATA_0,
  output logic [3:0] OE_DATA_0,
  output logic       DELAY_LINE_LOAD_0,
  output logic       DELAY_LINE_MOVE_0,
  output logic       DELAY_LINE_DIRECTION_0,
  output logic       TAP_ACK,
  output logic [6:0] TAP_POS,
  output logic       TAP_ERR,
  output logic       CKE_EN,
  output logic       BUSY
);
  localparam int MAXC = (T_RESET_CYCLES > T_CKE_CYCLES) ? T_RESET_CYCLES : T_CKE_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int GW   = $clog2(MOVE_GAP);
  localparam logic [CW-1:0] R_LD   = CW'(T_RESET_CYCLES - 1);
  localparam logic [CW-1:0] C_LD   = CW'(T_CKE_CYCLES - 1);
  localparam logic [GW-1:0] G_LD   = GW'(MOVE_GAP - 1);
  localparam logic [6:0]    TAP_HI = 7'(TAP_MAX);

  typedef enum logic [1:0] {LOAD, HOLD_LOW, WAIT_CKE, DONE} state_t;

  state_t        state, nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [GW-1:0] gap;
  logic          move_ok;

  // Outputs are registered from the next state so they line up with it.
  // LOAD is left once its load pulse is visible, which also gives the
  // one visible LOAD cycle straight after reset release.
  always_comb begin
    nxt     = state;
    cnt_nxt = cnt;
    case (state)
      LOAD:
        if (DELAY_LINE_LOAD_0) begin
          nxt     = HOLD_LOW;
          cnt_nxt = R_LD;
        end
      HOLD_LOW:
        if (cnt == '0) begin
          nxt     = WAIT_CKE;
          cnt_nxt = C_LD;
        end else cnt_nxt = cnt - CW'(1);
      WAIT_CKE:
        if (cnt == '0) begin
          nxt     = DONE;
          cnt_nxt = '0;
        end else cnt_nxt = cnt - CW'(1);
      DONE:
        if (INIT_REQ) nxt = LOAD;
      default: nxt = LOAD;
    endcase
    move_ok = TAP_MOVE_REQ && (state == DONE) && !INIT_REQ && (gap == '0);
  end

  always_ff @(posedge FAB_CLK) begin
    if (TX_SYNC_RST) begin
      state                  <= LOAD;
      cnt                    <= '0;
      gap                    <= '0;
      TX_DATA_0              <= 4'b0000;
      OE_DATA_0              <= 4'b1111;
      DELAY_LINE_LOAD_0      <= 1'b0;
      DELAY_LINE_MOVE_0      <= 1'b0;
      DELAY_LINE_DIRECTION_0 <= 1'b0;
      TAP_ACK                <= 1'b0;
      TAP_POS                <= '0;
      TAP_ERR                <= 1'b0;
      CKE_EN                 <= 1'b0;
      BUSY                   <= 1'b1;
    end else begin
      state             <= nxt;
      cnt               <= cnt_nxt;
      TX_DATA_0         <= (nxt == WAIT_CKE || nxt == DONE) ? 4'b1111 : 4'b0000;
      OE_DATA_0         <= 4'b1111;
      DELAY_LINE_LOAD_0 <= (nxt == LOAD);
      CKE_EN            <= (nxt == DONE);
      BUSY              <= (nxt != DONE);
      TAP_ACK           <= TAP_MOVE_REQ;
      DELAY_LINE_MOVE_0 <= move_ok;
      if (move_ok) DELAY_LINE_DIRECTION_0 <= TAP_DIR;
      if (move_ok)        gap <= G_LD;
      else if (gap != '0) gap <= gap - GW'(1);
      // Position follows the issued move one cycle later; saturation flags an error.
      if (nxt == LOAD) begin
        TAP_POS <= '0;
        TAP_ERR <= 1'b0;
      end else begin
        if (DELAY_LINE_MOVE_0) begin
          if (DELAY_LINE_DIRECTION_0) begin
            if (TAP_POS == TAP_HI) TAP_ERR <= 1'b1;
            else                   TAP_POS <= TAP_POS + 7'd1;
          end else begin
            if (TAP_POS == '0)     TAP_ERR <= 1'b1;
            else                   TAP_POS <= TAP_POS - 7'd1;
          end
        end
        if (DELAY_LINE_OUT_OF_RANGE_0) TAP_ERR <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_ddr3_reset_n_sequencer.sv
// Bench for ddr3_reset_n_sequencer: directed sequences, a tap-move vector
// table, and random stimulus against a cycle-time reference model.
module tb_ddr3_reset_n_sequencer;
  localparam int TR = 10;
  localparam int TC = 20;
  localparam int G  = 4;
  localparam int TM = 7;

  logic       FAB_CLK = 1'b0;
  logic       TX_SYNC_RST, INIT_REQ, TAP_MOVE_REQ, TAP_DIR, DELAY_LINE_OUT_OF_RANGE_0;
  logic [3:0] TX_DATA_0, OE_DATA_0;
  logic       DELAY_LINE_LOAD_0, DELAY_LINE_MOVE_0, DELAY_LINE_DIRECTION_0;
  logic       TAP_ACK, TAP_ERR, CKE_EN, BUSY;
  logic [6:0] TAP_POS;

  ddr3_reset_n_sequencer #(
    .T_RESET_CYCLES(TR), .T_CKE_CYCLES(TC), .MOVE_GAP(G), .TAP_MAX(TM)
  ) dut (
    .FAB_CLK(FAB_CLK), .TX_SYNC_RST(TX_SYNC_RST), .INIT_REQ(INIT_REQ),
    .TAP_MOVE_REQ(TAP_MOVE_REQ), .TAP_DIR(TAP_DIR),
    .DELAY_LINE_OUT_OF_RANGE_0(DELAY_LINE_OUT_OF_RANGE_0),
    .TX_DATA_0(TX_DATA_0), .OE_DATA_0(OE_DATA_0),
    .DELAY_LINE_LOAD_0(DELAY_LINE_LOAD_0), .DELAY_LINE_MOVE_0(DELAY_LINE_MOVE_0),
    .DELAY_LINE_DIRECTION_0(DELAY_LINE_DIRECTION_0), .TAP_ACK(TAP_ACK),
    .TAP_POS(TAP_POS), .TAP_ERR(TAP_ERR), .CKE_EN(CKE_EN), .BUSY(BUSY)
  );

  always #5 FAB_CLK = ~FAB_CLK;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: t is the sequence-relative cycle number of the visible outputs.
  int t        = 0;
  bit rst_vis  = 1'b1;
  int ecnt     = 0;
  int last_acc = -1000;
  int pos_m    = 0;
  bit err_m    = 1'b0;
  bit move_m   = 1'b0;
  bit ack_m    = 1'b0;
  bit dir_m    = 1'b0;

  task automatic model_edge(input bit rst, input bit init, input bit mv, input bit dir, input bit oor);
    bit prev_done;
    bit acc;
    ecnt++;
    if (rst) begin
      rst_vis = 1'b1; pos_m = 0; err_m = 1'b0; move_m = 1'b0;
      ack_m = 1'b0; dir_m = 1'b0; last_acc = -1000;
      return;
    end
    prev_done = !rst_vis && (t >= TR + TC + 1);
    if (move_m) begin
      if (dir_m) begin
        if (pos_m == TM) err_m = 1'b1; else pos_m++;
      end else begin
        if (pos_m == 0) err_m = 1'b1; else pos_m--;
      end
    end
    if (oor) err_m = 1'b1;
    acc    = mv && prev_done && !init && (ecnt - last_acc >= G);
    ack_m  = mv;
    move_m = acc;
    if (acc) begin
      dir_m    = dir;
      last_acc = ecnt;
    end
    if (rst_vis) begin
      t = 0; rst_vis = 1'b0;
    end else if (prev_done && init) t = 0;
    else t++;
    if (t == 0) begin
      pos_m = 0; err_m = 1'b0;
    end
  endtask

  function automatic logic [21:0] exp_vec();
    logic [3:0] tx;
    logic       ld, ck;
    if (rst_vis) begin
      tx = 4'h0; ld = 1'b0; ck = 1'b0;
    end else begin
      tx = (t >= TR + 1) ? 4'hf : 4'h0;
      ld = (t == 0);
      ck = (t >= TR + TC + 1);
    end
    return {tx, 4'hf, ld, move_m, dir_m, ack_m, 7'(pos_m), err_m, ck, ~ck};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (time %0t)", nm, got, exp, $time);
    end
  endtask

  task automatic step(input bit rst, input bit init, input bit mv, input bit dir, input bit oor);
    TX_SYNC_RST = rst; INIT_REQ = init; TAP_MOVE_REQ = mv; TAP_DIR = dir;
    DELAY_LINE_OUT_OF_RANGE_0 = oor;
    @(posedge FAB_CLK);
    model_edge(rst, init, mv, dir, oor);
    #1;
    chk("model", {10'b0, TX_DATA_0, OE_DATA_0, DELAY_LINE_LOAD_0, DELAY_LINE_MOVE_0,
                  DELAY_LINE_DIRECTION_0, TAP_ACK, TAP_POS, TAP_ERR, CKE_EN, BUSY},
        {10'b0, exp_vec()});
  endtask

  // Walks cycles 1 .. TR+TC+2 of a sequence whose cycle 0 was just stepped.
  task automatic walk(input int oor_at);
    for (int c = 1; c <= TR + TC + 2; c++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, c == oor_at);
      if (c == 1)            chk("load_one_cycle", DELAY_LINE_LOAD_0, 0);
      if (c == TR)           chk("tx_low_last", TX_DATA_0, 4'h0);
      if (c == TR + 1)       chk("tx_high_first", TX_DATA_0, 4'hf);
      if (c == TR + TC)      chk("cke_before", CKE_EN, 0);
      if (c == TR + TC + 1) begin
        chk("cke_rise", CKE_EN, 1);
        chk("busy_fall", BUSY, 0);
      end
      chk("oe_const", OE_DATA_0, 4'hf);
    end
  endtask

  typedef struct {
    bit       mv;
    bit       exp_move;
    bit [6:0] exp_pos;
  } tvec_t;
  tvec_t tv[19];

  initial begin
    int nacc;
    TX_SYNC_RST = 1'b1; INIT_REQ = 1'b0; TAP_MOVE_REQ = 1'b0; TAP_DIR = 1'b0;
    DELAY_LINE_OUT_OF_RANGE_0 = 1'b0;

    // Reset values
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_tx", TX_DATA_0, 4'h0);
    chk("rst_oe", OE_DATA_0, 4'hf);
    chk("rst_busy", BUSY, 1);
    chk("rst_cke", CKE_EN, 0);
    chk("rst_load", DELAY_LINE_LOAD_0, 0);

    // Release: LOAD at cycle 0, OOR during WAIT_CKE sets a sticky error
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("load_c0", DELAY_LINE_LOAD_0, 1);
    walk(16);
    chk("err_sticky", TAP_ERR, 1);

    // INIT and move in the same DONE cycle: INIT wins, move rejected
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("init_load", DELAY_LINE_LOAD_0, 1);
    chk("init_cke", CKE_EN, 0);
    chk("init_ack", TAP_ACK, 1);
    chk("init_nomove", DELAY_LINE_MOVE_0, 0);
    chk("init_errclr", TAP_ERR, 0);
    walk(-1);

    // Five spaced increments, then a too-early sixth request
    nacc = 0;
    for (int i = 0; i < 19; i++) begin
      tv[i].mv       = ((i % 4 == 0) && i <= 16) || i == 17;
      tv[i].exp_move = (i % 4 == 0) && i <= 16;
      tv[i].exp_pos  = 7'(nacc);
      if (tv[i].exp_move) nacc++;
    end
    for (int i = 0; i < 19; i++) begin
      step(1'b0, 1'b0, tv[i].mv, 1'b1, 1'b0);
      chk("tbl_move", DELAY_LINE_MOVE_0, tv[i].exp_move);
      chk("tbl_ack", TAP_ACK, tv[i].mv);
      chk("tbl_pos", TAP_POS, tv[i].exp_pos);
      if (tv[i].exp_move) chk("tbl_dir", DELAY_LINE_DIRECTION_0, 1);
    end
    chk("tbl_pos5", TAP_POS, 5);
    repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Upper saturation at TAP_MAX
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      chk("up_move", DELAY_LINE_MOVE_0, 1);
      repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (k == 1) chk("up_err_clear", TAP_ERR, 0);
    end
    chk("up_pos_max", TAP_POS, TM);
    chk("up_err_sat", TAP_ERR, 1);

    // Lower saturation at 0 after re-init
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    walk(-1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("dn_move", DELAY_LINE_MOVE_0, 1);
    chk("dn_dir", DELAY_LINE_DIRECTION_0, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("dn_pos0", TAP_POS, 0);
    chk("dn_err", TAP_ERR, 1);

    // Reset in the middle of HOLD_LOW, then a full-length restart
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (5) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("mid_rst_busy", BUSY, 1);
    chk("mid_rst_load", DELAY_LINE_LOAD_0, 0);
    chk("mid_rst_err", TAP_ERR, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("mid_rst_c0", DELAY_LINE_LOAD_0, 1);
    walk(-1);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 39) == 0,
           $urandom_range(0, 2) == 0, 1'($urandom), $urandom_range(0, 49) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
